weighted_rr_sched: RTL
======================

WEIGHTED_RR_SCHED -- requirements
Module: weighted_rr_sched

Interface
REQ-001 Parameter DATA_W, default 10, width of every data word.
REQ-002 Parameter DEST_LSB, default 8, LSB of the 2-bit destination field data[DEST_LSB+1:DEST_LSB].
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 empty_in  input  4  bit i = input FIFO Pi empty.
REQ-006 data_in0..data_in3  input  DATA_W each  read data of input FIFO Pi, valid the cycle after its pop.
REQ-007 almost_full_out  input  4  bit j = output FIFO Fj cannot accept a push this cycle.
REQ-008 weight_cfg  input  8  2 bits per port (port i = bits 2i+1:2i); burst weight = field+1 (1..4).
REQ-009 cfg_load  input  1  latches weight_cfg into internal weight registers at posedge.
REQ-010 pop_in  output  4  one-hot-or-zero pop to input FIFOs.
REQ-011 push_out  output  4  one-hot-or-zero push to output FIFOs.
REQ-012 data_out  output  DATA_W  word broadcast to all output FIFOs, qualified by push_out.
REQ-013 grant_port  output  2  current round-robin pointer.
REQ-014 hold_active  output  1  high while in HOLD state.

Function
REQ-015 State machine SHALL have two states: RUN and HOLD.
REQ-016 Pointer ptr[1:0] and credit counter cnt[2:0] SHALL select the port popped each cycle.
REQ-017 In RUN, pop_in[ptr] SHALL assert when Pi not empty, cnt < weight[ptr], and no stall (REQ-021); cnt increments on each pop.
REQ-018 When cnt = weight[ptr] or Pi empty, ptr SHALL move that same cycle to the first non-empty port searched ptr+1, ptr+2, ptr+3, ptr (wrap-around); cnt restarts at 0 and the new port pops in that cycle if not stalled.
REQ-019 All inputs empty: no pop, ptr and cnt hold.
REQ-020 Pop latency: word popped at cycle t SHALL be presented on data_out at t+1, with push_out[dest] asserted combinationally in t+1 when almost_full_out[dest]=0.
REQ-021 Stall: if at cycle t+1 the in-flight word's dest has almost_full_out[dest]=1, no push and no pop occur; the word is captured in a 1-entry hold register; state goes to HOLD.
REQ-022 In HOLD, pop_in SHALL be 0; each cycle with almost_full_out[hold_dest]=0 the held word is pushed and state returns to RUN; pops resume the following cycle.
REQ-023 At most one push and one pop per cycle; no word duplicated or dropped except at reset.
REQ-024 cfg_load takes effect at the next cycle's grant decision; if cnt >= new weight[ptr], ptr advances per REQ-018.
REQ-025 cfg_load in HOLD SHALL update weights without releasing HOLD.
REQ-026 Destination field is taken from the word itself; source port does not affect routing.

Reset
REQ-027 While reset=1 at posedge: state=RUN, ptr=0, cnt=0, weights=0 (weight 1, plain round robin), in-flight valid and hold register cleared.
REQ-028 During and the cycle after reset, pop_in=0, push_out=0, data_out=0, grant_port=0, hold_active=0.
REQ-029 Reset mid-transfer SHALL discard the in-flight or held word without push.

Structure
REQ-030 Shared package SHALL hold DATA_W, DEST_LSB, NPORTS=4, state encoding (RUN, HOLD), and weight field width.
REQ-031 Sub-module rr_next_port SHALL implement the 4-way wrap-around search of REQ-018 (inputs ptr, empty_in; outputs next port, any_valid).
REQ-032 Target size 150-300 lines of RTL plus package.

Verification
REQ-033 Reset, weights 0, all inputs non-empty, all outputs free -> pop_in sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-034 cfg_load weight_cfg=8'b00_00_00_11 -> P0 popped 4 consecutive cycles, then P1, P2, P3 once each, then P0 again.
REQ-035 P0 word 10'b10_00000101 popped, almost_full_out=0100 next cycle -> no push, hold_active=1, pop_in=0; almost_full_out=0000 -> push_out=0100, data_out=0x205, next cycle pops resume.
REQ-036 Only P2 non-empty, weight 1 -> pop_in=0100 every cycle, grant_port stays 2.
REQ-037 P1 becomes empty mid-burst (weight 4, cnt=2) -> ptr advances to P2 same cycle, no idle cycle.
REQ-038 reset asserted in HOLD -> held word never pushed, ptr=0, hold_active=0 next cycle.

Source files
------------

// File: rtl/weighted_rr_sched_pkg.sv
// Shared types and sizing for the weighted round-robin scheduler.
package weighted_rr_sched_pkg;

  localparam int unsigned DEF_DATA_W   = 10;
  localparam int unsigned DEF_DEST_LSB = 8;
  localparam int unsigned NPORTS       = 4;
  localparam int unsigned PTR_W        = 2;
  localparam int unsigned DEST_W       = 2;
  localparam int unsigned WFIELD_W     = 2;
  localparam int unsigned CFG_W        = NPORTS * WFIELD_W;
  localparam int unsigned CNT_W        = 3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  // Burst length encoded by a weight field: field value plus one.
  function automatic logic [CNT_W-1:0] weight_of(input logic [WFIELD_W-1:0] field);
    return CNT_W'(field) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/weighted_rr_sched_rr_next_port.sv
// Wrap-around search for the first non-empty port after the current pointer.
module rr_next_port
  import weighted_rr_sched_pkg::*;
(
  input  logic [PTR_W-1:0]  i_ptr,
  input  logic [NPORTS-1:0] i_empty_in,
  output logic [PTR_W-1:0]  o_next_port,
  output logic              o_any_valid
);

  // Search order ptr+1, ptr+2, ptr+3, ptr; the first hit wins.
  always_comb begin
    o_next_port = i_ptr;
    o_any_valid = 1'b0;
    for (int k = 1; k <= int'(NPORTS); k++) begin
      if (!o_any_valid && !i_empty_in[i_ptr + PTR_W'(k)]) begin
        o_next_port = i_ptr + PTR_W'(k);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_sched.sv
// Weighted round-robin scheduler: moves words from 4 input FIFOs to 4 output
// FIFOs routed by a destination field, with a one-entry hold on back-pressure.
module weighted_rr_sched
  import weighted_rr_sched_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEST_LSB = DEF_DEST_LSB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] empty_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [NPORTS-1:0] almost_full_out,
  input  logic [CFG_W-1:0]  weight_cfg,
  input  logic              cfg_load,
  output logic [NPORTS-1:0] pop_in,
  output logic [NPORTS-1:0] push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [PTR_W-1:0]  grant_port,
  output logic              hold_active
);

  sched_state_e          r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [WFIELD_W-1:0]   r_weight [NPORTS];
  logic                  r_if_valid, w_if_valid_nxt;
  logic [PTR_W-1:0]      r_if_src, w_if_src_nxt;
  logic [DATA_W-1:0]     r_hold_data, w_hold_data_nxt;
  logic                  r_post_rst;

  logic [DATA_W-1:0]     w_data_in [NPORTS];
  logic [DATA_W-1:0]     w_if_data;
  logic [DEST_W-1:0]     w_if_dest;
  logic [DEST_W-1:0]     w_hold_dest;
  logic [CNT_W-1:0]      w_cur_weight;
  logic [PTR_W-1:0]      w_next_port;
  logic                  w_any_valid;
  logic                  w_stall;

  assign w_data_in[0] = data_in0;
  assign w_data_in[1] = data_in1;
  assign w_data_in[2] = data_in2;
  assign w_data_in[3] = data_in3;

  // The word popped last cycle is on its FIFO's read port now.
  assign w_if_data    = w_data_in[r_if_src];
  assign w_if_dest    = w_if_data[DEST_LSB +: DEST_W];
  assign w_hold_dest  = r_hold_data[DEST_LSB +: DEST_W];
  assign w_cur_weight = weight_of(r_weight[r_ptr]);

  assign grant_port  = reset ? '0 : r_ptr;
  assign hold_active = (r_state == ST_HOLD) && !reset;

  rr_next_port u_next (
    .i_ptr       (r_ptr),
    .i_empty_in  (empty_in),
    .o_next_port (w_next_port),
    .o_any_valid (w_any_valid)
  );

  // Grant, push and hold decisions; nothing moves during or just after reset.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_if_valid_nxt  = 1'b0;
    w_if_src_nxt    = r_if_src;
    w_hold_data_nxt = r_hold_data;
    w_stall         = 1'b0;
    pop_in          = '0;
    push_out        = '0;
    data_out        = '0;
    if (!reset && !r_post_rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (r_if_valid) begin
            data_out = w_if_data;
            if (almost_full_out[w_if_dest]) begin
              w_stall         = 1'b1;
              w_hold_data_nxt = w_if_data;
              w_state_nxt     = ST_HOLD;
            end else begin
              push_out[w_if_dest] = 1'b1;
            end
          end
          if (!w_stall) begin
            if (!empty_in[r_ptr] && (r_cnt < w_cur_weight)) begin
              pop_in[r_ptr]  = 1'b1;
              w_cnt_nxt      = r_cnt + CNT_W'(1);
              w_if_valid_nxt = 1'b1;
              w_if_src_nxt   = r_ptr;
            end else if (w_any_valid) begin
              pop_in[w_next_port] = 1'b1;
              w_ptr_nxt           = w_next_port;
              w_cnt_nxt           = CNT_W'(1);
              w_if_valid_nxt      = 1'b1;
              w_if_src_nxt        = w_next_port;
            end
          end
        end
        ST_HOLD: begin
          data_out = r_hold_data;
          if (!almost_full_out[w_hold_dest]) begin
            push_out[w_hold_dest] = 1'b1;
            w_state_nxt           = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // State, pointer, credit, in-flight tracking and weight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_if_valid  <= 1'b0;
      r_if_src    <= '0;
      r_hold_data <= '0;
      r_post_rst  <= 1'b1;
      for (int i = 0; i < int'(NPORTS); i++) r_weight[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_src    <= w_if_src_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_post_rst  <= 1'b0;
      if (cfg_load) begin
        for (int i = 0; i < int'(NPORTS); i++)
          r_weight[i] <= weight_cfg[i*int'(WFIELD_W) +: WFIELD_W];
      end
    end
  end

endmodule
